jtframe_objdma: RTL
===================

// Module: jtframe_objdma
// PURPOSE
//  Parametrised object-RAM DMA engine: on dma_go it requests the CPU bus
//  (busrq/busak_n), copies LEN words from CPU-side RAM at SRC_BASE into the
//  object line buffer, then releases the bus.
//  Successor to the fixed 512-byte DMA used by the Pang-class video: generic
//  in length, data width and start condition, and adds queued requests,
//  bus-loss pause and a completion pulse.
//  Sits between the main CPU bus arbiter and the object engine.
// PARAMETERS
//  SAW        12     source address width
//  DAW        9      destination address width; LEN <= 2**DAW
//  DW         8      data width
//  LEN        512    words per transfer, 1..2**DAW
//  SRC_BASE   0      first source address; wraps modulo 2**SAW
//  WAIT_BLANK 1      1: start only while LVBL=0; 0: start immediately
// PORTS
//  clk       in   1    system clock
//  rst       in   1    asynchronous reset, active high
//  cen       in   1    transfer pacing clock enable; one word per cen
//  LVBL      in   1    vertical blank, active low
//  dma_go    in   1    start request, sampled every clk (level or pulse)
//  busrq     out  1    bus request to CPU, active high
//  busak_n   in   1    bus acknowledge from CPU, active low
//  src_addr  out  SAW  CPU RAM read address (RAM read latency 1 clk)
//  src_data  in   DW   CPU RAM read data
//  dst_addr  out  DAW  object buffer write address
//  dst_data  out  DW   object buffer write data
//  dst_we    out  1    object buffer write strobe, one clk wide
//  busy      out  1    high from start accept until bus released
//  done      out  1    one-clk pulse when bus released after a transfer
// BEHAVIOUR
//  Reset: busrq=0, dst_we=0, busy=0, done=0; src_addr=SRC_BASE, dst_addr=0,
//  dst_data=0; state IDLE; pending=0; counter=0.
//  Reset mid-transfer drops busrq at once; a partial copy is not resumed.
//  States:
//   IDLE    dma_go=1 -> ARM, busy<=1
//   ARM     WAIT_BLANK=0 or LVBL=0 -> REQ, busrq<=1
//   REQ     busak_n=0 -> PRIME
//   PRIME   on cen: src_addr<=SRC_BASE, cnt<=0 -> XFER
//   XFER    on cen with busak_n=0:
//            dst_we<=1 for 1 clk, dst_addr<=cnt, dst_data<=src_data,
//            src_addr<=src_addr+1, cnt<=cnt+1
//           after the write with cnt=LEN-1 -> REL, busrq<=0
//   REL     busak_n=1 -> done<=1 (1 clk), busy<=0;
//           pending ? ARM (pending<=0, busy<=1) : IDLE
//  src_data is captured on a cen at least one clk after src_addr changed;
//  every word meets the 1-clk RAM latency.
//  dst_we is only asserted in XFER on a cen clk (plus 1 register stage).
//  There is never more than one write per cen.
//  Bus loss: busak_n=1 during XFER pauses the copy. No writes occur,
//  cnt/src_addr hold and busrq stays 1. The copy resumes on the first cen
//  after busak_n=0. The word latched next is re-read from the held src_addr.
//  dma_go while busy sets pending (one deep; extra requests merge).
//  A pending request restarts from SRC_BASE after the current done.
//  dma_go on the same clk as done: that request becomes pending.
//  src_addr wraps modulo 2**SAW; dst_addr never exceeds LEN-1.
//  LEN=1: a single write, then REL.
//  Latency with WAIT_BLANK=0 and busak_n granted immediately:
//   dma_go to busrq = 2 clk;
//   first dst_we = 2 cen after busak_n low;
//   busrq release = LEN+1 cen after busak_n low.
//  LVBL is only checked in ARM; a transfer that crosses out of blank is
//  completed.
// TESTING
//  1. LEN=512, WAIT_BLANK=0, busak_n follows busrq after 3 clk,
//     src_data=src_addr[7:0].
//     -> 512 dst_we; dst_data==dst_addr[7:0]; one done pulse; busy low after.
//  2. WAIT_BLANK=1, dma_go with LVBL=1 for 100 clk, then LVBL=0.
//     -> busrq stays 0 while LVBL=1, rises 1 clk after LVBL falls.
//  3. Raise busak_n for 20 clk at cnt=100.
//     -> no dst_we during the gap; word 100 written once with the correct data;
//        total writes still LEN.
//  4. dma_go three times during busy.
//     -> exactly two transfers and two done pulses.
//  5. Assert rst at cnt=37.
//     -> busrq, busy and dst_we are 0 in the same clk; IDLE after release.
//  6. SRC_BASE=12'hFF0, SAW=12, LEN=32.
//     -> src_addr runs FF0..FFF then 000..00F; dst_addr runs 0..31.

Source files
------------

// File: rtl/jtframe_objdma.sv
// jtframe_objdma
// Object-RAM DMA engine. On dma_go it requests the CPU bus, copies LEN words
// from CPU-side RAM starting at SRC_BASE into the object line buffer, one word
// per cen, then releases the bus and pulses done.
//
// Ports
//   clk       system clock
//   rst       asynchronous reset, active high
//   cen       transfer pacing enable, at most one word per cen
//   LVBL      vertical blank, active low (start gate when WAIT_BLANK=1)
//   dma_go    start request, level or pulse
//   busrq     bus request to CPU, active high
//   busak_n   bus acknowledge from CPU, active low
//   src_addr  CPU RAM read address (RAM data valid one clk later)
//   src_data  CPU RAM read data
//   dst_addr  object buffer write address
//   dst_data  object buffer write data
//   dst_we    object buffer write strobe, one clk wide
//   busy      high from start accept until the bus is released
//   done      one-clk pulse when the bus is released after a transfer
//
// State  | meaning
// IDLE   | waiting for dma_go
// ARM    | request accepted, waiting for blank (if enabled)
// REQ    | busrq raised, waiting for busak_n
// PRIME  | load first source address on a cen
// XFER   | one word copied per cen while the bus is held
// REL    | busrq dropped, waiting for the CPU to take the bus back
module jtframe_objdma #(
    parameter int               SAW        = 12,
    parameter int               DAW        = 9,
    parameter int               DW         = 8,
    parameter int               LEN        = 512,
    parameter logic [SAW-1:0]   SRC_BASE   = '0,
    parameter bit               WAIT_BLANK = 1'b1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            LVBL,
    input  logic            dma_go,
    output logic            busrq,
    input  logic            busak_n,
    output logic [SAW-1:0]  src_addr,
    input  logic [DW-1:0]   src_data,
    output logic [DAW-1:0]  dst_addr,
    output logic [DW-1:0]   dst_data,
    output logic            dst_we,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        REQ   = 3'd2,
        PRIME = 3'd3,
        XFER  = 3'd4,
        REL   = 3'd5
    } state_t;

    localparam logic [DAW-1:0] LAST = DAW'(LEN - 1);

    state_t          state_q,    state_d;
    logic            pending_q,  pending_d;
    logic            busrq_q,    busrq_d;
    logic            busy_q,     busy_d;
    logic            done_q,     done_d;
    logic            dst_we_q,   dst_we_d;
    logic [SAW-1:0]  src_addr_q, src_addr_d;
    logic [DAW-1:0]  dst_addr_q, dst_addr_d;
    logic [DW-1:0]   dst_data_q, dst_data_d;
    logic [DAW-1:0]  cnt_q,      cnt_d;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        busrq_d    = busrq_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dst_we_d   = 1'b0;
        src_addr_d = src_addr_q;
        dst_addr_d = dst_addr_q;
        dst_data_d = dst_data_q;
        cnt_d      = cnt_q;

        // Requests arriving while a transfer is in flight merge into one
        if (state_q != IDLE && dma_go) pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (dma_go) begin
                    state_d = ARM;
                    busy_d  = 1'b1;
                end
            end
            ARM: begin
                if (!WAIT_BLANK || !LVBL) begin
                    state_d = REQ;
                    busrq_d = 1'b1;
                end
            end
            REQ: begin
                if (!busak_n) state_d = PRIME;
            end
            PRIME: begin
                // Address goes out here so src_data is settled by the next cen
                if (cen) begin
                    src_addr_d = SRC_BASE;
                    cnt_d      = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                // Losing the bus simply stalls here with address and count held
                if (cen && !busak_n) begin
                    dst_we_d   = 1'b1;
                    dst_addr_d = cnt_q;
                    dst_data_d = src_data;
                    src_addr_d = src_addr_q + SAW'(1);
                    cnt_d      = cnt_q + DAW'(1);
                    if (cnt_q == LAST) begin
                        state_d = REL;
                        busrq_d = 1'b0;
                    end
                end
            end
            REL: begin
                if (busak_n) begin
                    done_d    = 1'b1;
                    pending_d = 1'b0;
                    // A request on this very clk counts as pending
                    if (pending_q || dma_go) begin
                        state_d = ARM;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busrq_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            busrq_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dst_we_q   <= 1'b0;
            src_addr_q <= SRC_BASE;
            dst_addr_q <= '0;
            dst_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            busrq_q    <= busrq_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dst_we_q   <= dst_we_d;
            src_addr_q <= src_addr_d;
            dst_addr_q <= dst_addr_d;
            dst_data_q <= dst_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busrq    = busrq_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dst_we   = dst_we_q;
    assign src_addr = src_addr_q;
    assign dst_addr = dst_addr_q;
    assign dst_data = dst_data_q;

endmodule
